wb_master_arbiter: RTL
======================

WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: cycles without p_wb_ACK_I before a stalled transfer is aborted (watchdog build only).
REQ-002 Parameter M1_PRIO, default 1: when 1, master 1 (video_out fetch) wins simultaneous requests from idle; when 0, requests are arbitrated round-robin.
REQ-003 clk  in  1  system clock; all logic is on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 mK_CYC_I, mK_STB_I, mK_LOCK_I, mK_WE_I (K=0,1)  in  1 each  requester bus-cycle signals; master 0 is video_in_store, master 1 is the video_out fetch.
REQ-006 mK_SEL_I  in  4; mK_ADR_I  in  32; mK_DAT_I  in  32  requester byte selects, address and write data.
REQ-007 mK_ACK_O  out  1; mK_ERR_O  out  1  per-requester acknowledge and error.
REQ-008 m_DAT_O  out  32  read data, p_wb_DAT_I passed through to both requesters.
REQ-009 p_wb_CYC_O, p_wb_STB_O, p_wb_LOCK_O, p_wb_WE_O  out  1 each; p_wb_SEL_O  out  4; p_wb_ADR_O, p_wb_DAT_O  out  32  shared master port.
REQ-010 p_wb_ACK_I, p_wb_ERR_I  in  1 each; p_wb_DAT_I  in  32  shared slave response.
REQ-011 grant  out  2  one-hot owner: 01 is master 0, 10 is master 1, 00 is idle.
REQ-012 timeout_irq  out  1  one-cycle pulse when a transfer is aborted.

Function
REQ-013 FSM states: IDLE, OWN0, OWN1, ABORT; the FSM is registered, and only the outputs are combinational from state.
REQ-014 IDLE: if only mK_CYC_I=1, go to OWNK on the next edge.
REQ-015 IDLE, both requesting: go to OWN1 when M1_PRIO=1; otherwise go to the master not served last, and use master 0 first after reset.
REQ-016 In OWNK, the shared port outputs equal master K's inputs, combinationally, with zero cycles of latency.
REQ-017 In OWNK, mK_ACK_O equals p_wb_ACK_I and mK_ERR_O equals p_wb_ERR_I; the non-owner's ACK/ERR are held at 0.
REQ-018 In IDLE and ABORT, p_wb_CYC_O and p_wb_STB_O are 0 and all other shared outputs are 0.
REQ-019 Ownership is released only when mK_CYC_I=0 and mK_LOCK_I=0; the next edge then goes to IDLE.
REQ-020 While mK_LOCK_I=1, the owner is kept even if mK_CYC_I drops, so no other master can interleave.
REQ-021 Release-to-new-grant costs one IDLE cycle; there is no back-to-back handover in the same cycle.
REQ-022 Last-served owner: a 1-bit register updated on every entry to OWNK; it feeds round-robin only.
REQ-023 p_wb_ACK_I or p_wb_ERR_I while in IDLE or ABORT is ignored and forwarded to nobody.
REQ-024 A requester dropping CYC mid-wait for ACK is legal; the arbiter follows CYC and does not hold the bus.

Reset
REQ-025 On reset_n=0, asynchronously: state=IDLE, grant=00, and last-served indicates master 1, so master 0 wins the first round-robin.
REQ-026 On reset_n=0, asynchronously: every output is 0, including timeout_irq, mK_ACK_O, mK_ERR_O and all p_wb_* outputs.
REQ-027 On reset_n=0, the watchdog counter is 0.
REQ-028 Reset asserted mid-transfer drops p_wb_CYC_O immediately, with no completion of the pending access.

Configuration
REQ-029 Macro WB_ARB_TIMEOUT_EN defined: an 8-bit or wider counter clears on entry to OWNK and on each p_wb_ACK_I or p_wb_ERR_I.
REQ-030 With WB_ARB_TIMEOUT_EN defined, the counter increments every OWNK cycle with p_wb_STB_O=1.
REQ-031 With WB_ARB_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES moves the FSM to ABORT for one cycle.
REQ-032 In that ABORT cycle: mK_ERR_O=1 for the owner, timeout_irq=1, and the bus is released; the next state is IDLE.
REQ-033 Macro WB_ARB_TIMEOUT_EN undefined: no counter, ABORT is unreachable, and timeout_irq is tied to 0.

Verification
REQ-034 Only m0 requests, write to ADR 0x0000_1000, ACK on the 3rd cycle -> grant=01 one cycle after CYC; p_wb_ADR_O=0x1000; m0_ACK_O pulses once; grant=00 after CYC drops.
REQ-035 Both request in the same cycle, M1_PRIO=1 -> OWN1 first; m0 is granted exactly one IDLE cycle after m1 releases.
REQ-036 M1_PRIO=0, both hold CYC continuously with 4-beat bursts, releasing between bursts -> grants alternate 01,10,01,10.
REQ-037 m0 holds LOCK=1, drops CYC for 2 cycles, while m1 requests -> grant stays 01 until LOCK=0; m1_ACK_O stays 0 throughout.
REQ-038 WB_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, slave never ACKs -> after 16 STB cycles, one-cycle m-owner ERR and timeout_irq; grant=00; no p_wb_CYC_O afterwards.
REQ-039 reset_n pulsed low during OWN1 -> within the same cycle, every output is 0; after release, the first request from m0 is granted.

Source files
------------

// File: rtl/wb_master_arbiter.sv
// ============================================================================
// Module      : wb_master_arbiter
// Description : Two-requester Wishbone arbiter (video_in_store = master 0,
//               video_out fetch = master 1) onto one shared master port.
//               Optional stall watchdog enabled by macro WB_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_master_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter bit M1_PRIO        = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        m0_CYC_I,
    input  logic        m0_STB_I,
    input  logic        m0_LOCK_I,
    input  logic        m0_WE_I,
    input  logic [3:0]  m0_SEL_I,
    input  logic [31:0] m0_ADR_I,
    input  logic [31:0] m0_DAT_I,
    output logic        m0_ACK_O,
    output logic        m0_ERR_O,

    input  logic        m1_CYC_I,
    input  logic        m1_STB_I,
    input  logic        m1_LOCK_I,
    input  logic        m1_WE_I,
    input  logic [3:0]  m1_SEL_I,
    input  logic [31:0] m1_ADR_I,
    input  logic [31:0] m1_DAT_I,
    output logic        m1_ACK_O,
    output logic        m1_ERR_O,

    output logic [31:0] m_DAT_O,

    output logic        p_wb_CYC_O,
    output logic        p_wb_STB_O,
    output logic        p_wb_LOCK_O,
    output logic        p_wb_WE_O,
    output logic [3:0]  p_wb_SEL_O,
    output logic [31:0] p_wb_ADR_O,
    output logic [31:0] p_wb_DAT_O,
    input  logic        p_wb_ACK_I,
    input  logic        p_wb_ERR_I,
    input  logic [31:0] p_wb_DAT_I,

    output logic [1:0]  grant,
    output logic        timeout_irq
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_OWN0  = 2'd1;
    localparam logic [1:0] S_OWN1  = 2'd2;
    localparam logic [1:0] S_ABORT = 2'd3;

    logic [1:0] state;
    logic [1:0] next_state;
    // 1 = master 1 was the most recent owner; also names the owner during ABORT
    logic       last_served;
    logic       owning;
    logic       wd_expire;

    assign owning = (state == S_OWN0) || (state == S_OWN1);

    // ------------------------------------------------------------------
    // Stall watchdog
    // ------------------------------------------------------------------
`ifdef WB_ARB_TIMEOUT_EN
    localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt <= '0;
        end else if (!owning) begin
            wd_cnt <= '0;
        end else if (p_wb_ACK_I || p_wb_ERR_I) begin
            wd_cnt <= '0;
        end else if (p_wb_STB_O) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Fires on the TIMEOUT_CYCLES-th unanswered strobe cycle
    assign wd_expire = owning && p_wb_STB_O && !p_wb_ACK_I && !p_wb_ERR_I &&
                       (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_param;

    assign unused_timeout_param = (TIMEOUT_CYCLES == 0);
    assign wd_expire            = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Arbitration FSM
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (m0_CYC_I && m1_CYC_I) begin
                    if (M1_PRIO) begin
                        next_state = S_OWN1;
                    end else begin
                        next_state = last_served ? S_OWN0 : S_OWN1;
                    end
                end else if (m1_CYC_I) begin
                    next_state = S_OWN1;
                end else if (m0_CYC_I) begin
                    next_state = S_OWN0;
                end
            end
            S_OWN0: begin
                if (wd_expire) begin
                    next_state = S_ABORT;
                end else if (!m0_CYC_I && !m0_LOCK_I) begin
                    next_state = S_IDLE;
                end
            end
            S_OWN1: begin
                if (wd_expire) begin
                    next_state = S_ABORT;
                end else if (!m1_CYC_I && !m1_LOCK_I) begin
                    next_state = S_IDLE;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            last_served <= 1'b1;
        end else begin
            state <= next_state;
            if (state == S_IDLE && next_state == S_OWN0) begin
                last_served <= 1'b0;
            end else if (state == S_IDLE && next_state == S_OWN1) begin
                last_served <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output steering: pure function of state plus the owner's signals
    // ------------------------------------------------------------------
    always_comb begin
        p_wb_CYC_O  = 1'b0;
        p_wb_STB_O  = 1'b0;
        p_wb_LOCK_O = 1'b0;
        p_wb_WE_O   = 1'b0;
        p_wb_SEL_O  = 4'h0;
        p_wb_ADR_O  = 32'h0;
        p_wb_DAT_O  = 32'h0;
        m0_ACK_O    = 1'b0;
        m0_ERR_O    = 1'b0;
        m1_ACK_O    = 1'b0;
        m1_ERR_O    = 1'b0;
        m_DAT_O     = 32'h0;
        grant       = 2'b00;
        timeout_irq = 1'b0;
        case (state)
            S_OWN0: begin
                p_wb_CYC_O  = m0_CYC_I;
                p_wb_STB_O  = m0_STB_I;
                p_wb_LOCK_O = m0_LOCK_I;
                p_wb_WE_O   = m0_WE_I;
                p_wb_SEL_O  = m0_SEL_I;
                p_wb_ADR_O  = m0_ADR_I;
                p_wb_DAT_O  = m0_DAT_I;
                m0_ACK_O    = p_wb_ACK_I;
                m0_ERR_O    = p_wb_ERR_I;
                m_DAT_O     = p_wb_DAT_I;
                grant       = 2'b01;
            end
            S_OWN1: begin
                p_wb_CYC_O  = m1_CYC_I;
                p_wb_STB_O  = m1_STB_I;
                p_wb_LOCK_O = m1_LOCK_I;
                p_wb_WE_O   = m1_WE_I;
                p_wb_SEL_O  = m1_SEL_I;
                p_wb_ADR_O  = m1_ADR_I;
                p_wb_DAT_O  = m1_DAT_I;
                m1_ACK_O    = p_wb_ACK_I;
                m1_ERR_O    = p_wb_ERR_I;
                m_DAT_O     = p_wb_DAT_I;
                grant       = 2'b10;
            end
`ifdef WB_ARB_TIMEOUT_EN
            S_ABORT: begin
                m0_ERR_O    = !last_served;
                m1_ERR_O    = last_served;
                timeout_irq = 1'b1;
            end
`endif
            default: begin
                grant = 2'b00;
            end
        endcase
    end

endmodule

`default_nettype wire
